// File: rtl/cordic_floatingpoint_addsub_pipe_adder.sv
// Pipelined carry-lookahead add/subtract for the CORDIC mantissa datapath, with valid/ready flow.
// Optional macro CORDIC_ADDSUB_OVF_EN adds a registered two's-complement overflow output oOvf.
module cordic_floatingpoint_addsub_pipe_adder #(
  parameter int unsigned WIDTH         = 24,
  parameter int unsigned BLOCK         = 4,
  parameter int unsigned BLK_PER_STAGE = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iAddSub,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oS,
  output logic             oC
`ifdef CORDIC_ADDSUB_OVF_EN
  ,
  output logic             oOvf
`endif
);

  localparam int W    = int'(WIDTH);
  localparam int BLK  = int'(BLOCK);
  localparam int BPS  = int'(BLK_PER_STAGE);
  localparam int NBLK = (W + BLK - 1) / BLK;
  localparam int LAT  = (NBLK + BPS - 1) / BPS;

  // Entry k holds the state leaving stage k; entry LAT-1 is the output register.
  logic [WIDTH-1:0] a_q [LAT];
  logic [WIDTH-1:0] a_d [LAT];
  logic [WIDTH-1:0] b_q [LAT];
  logic [WIDTH-1:0] b_d [LAT];
  logic [WIDTH-1:0] s_q [LAT];
  logic [WIDTH-1:0] s_d [LAT];
  logic             c_q [LAT];
  logic             c_d [LAT];
  logic             m_q [LAT];
  logic             m_d [LAT];
  logic             v_q [LAT];
  logic             v_d [LAT];

`ifdef CORDIC_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  logic advance;

  assign advance = !v_q[LAT-1] || iReady;
  assign oReady  = advance;
  assign oValid  = v_q[LAT-1];
  assign oS      = s_q[LAT-1];
  assign oC      = c_q[LAT-1];
`ifdef CORDIC_ADDSUB_OVF_EN
  assign oOvf    = ovf_q;
`endif

  always_comb begin
    logic [WIDTH-1:0] st_a [LAT];
    logic [WIDTH-1:0] st_b [LAT];
    logic [WIDTH-1:0] st_s [LAT];
    logic             st_c [LAT];
    logic             st_m [LAT];
    logic             st_v [LAT];
    logic [WIDTH-1:0] op_a, op_b, sum;
    logic             cy, c_bit, bg, bp, gi, pi;
`ifdef CORDIC_ADDSUB_OVF_EN
    logic             ci_msb;
    ci_msb = 1'b0;
`endif

    st_a[0] = iA;
    st_b[0] = iB ^ {WIDTH{iAddSub}};
    st_s[0] = '0;
    st_c[0] = iAddSub;
    st_m[0] = iAddSub;
    st_v[0] = iValid;
    for (int k = 1; k < LAT; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_s[k] = s_q[k-1];
      st_c[k] = c_q[k-1];
      st_m[k] = m_q[k-1];
      st_v[k] = v_q[k-1];
    end

    for (int k = 0; k < LAT; k++) begin
      op_a = st_a[k];
      op_b = st_b[k];
      sum  = st_s[k];
      cy   = st_c[k];
      for (int blk = k * BPS; blk < (k + 1) * BPS && blk < NBLK; blk++) begin
        bg    = 1'b0;
        bp    = 1'b1;
        c_bit = cy;
        for (int i = blk * BLK; i < (blk + 1) * BLK && i < W; i++) begin
          gi     = op_a[i] & op_b[i];
          pi     = op_a[i] ^ op_b[i];
          sum[i] = pi ^ c_bit;
`ifdef CORDIC_ADDSUB_OVF_EN
          if (i == W - 1) ci_msb = c_bit;
`endif
          c_bit   = gi | (pi & c_bit);
          bg      = gi | (pi & bg);
          bp      = bp & pi;
          // Consumed operand bits are dropped so the skew registers trim away.
          op_a[i] = 1'b0;
          op_b[i] = 1'b0;
        end
        // Block carry-out from group generate/propagate; a narrow top block uses its own top bit.
        cy = bg | (bp & cy);
      end
      a_d[k] = op_a;
      b_d[k] = op_b;
      s_d[k] = sum;
      m_d[k] = st_m[k];
      v_d[k] = st_v[k];
      c_d[k] = (k == LAT - 1) ? (cy ^ st_m[k]) : cy;
    end

`ifdef CORDIC_ADDSUB_OVF_EN
    ovf_d = ci_msb ^ (c_d[LAT-1] ^ m_d[LAT-1]);
`endif
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int k = 0; k < LAT; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
`ifdef CORDIC_ADDSUB_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (advance) begin
      for (int k = 0; k < LAT; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        m_q[k] <= m_d[k];
        v_q[k] <= v_d[k];
      end
`ifdef CORDIC_ADDSUB_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_cordic_floatingpoint_addsub_pipe_adder.sv
// Directed bench for the pipelined CLA add/sub: default 24-bit build plus a 10-bit narrow-block build.
module tb_cordic_floatingpoint_addsub_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, rdy_in, addsub;
  logic [23:0] a, b;
  logic        rdy_o, vld_o, c_o;
  logic [23:0] s_o;

  logic       n_valid, n_addsub, n_rdy_in;
  logic [9:0] n_a, n_b;
  logic       n_rdy_o, n_vld_o, n_c_o;
  logic [9:0] n_s_o;

`ifdef CORDIC_ADDSUB_OVF_EN
  logic ovf_o, n_ovf_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  cordic_floatingpoint_addsub_pipe_adder dut (
    .iClk(clk), .iRst(rst), .iValid(valid), .oReady(rdy_o), .iA(a), .iB(b),
    .iAddSub(addsub), .oValid(vld_o), .iReady(rdy_in), .oS(s_o), .oC(c_o)
`ifdef CORDIC_ADDSUB_OVF_EN
    , .oOvf(ovf_o)
`endif
  );

  cordic_floatingpoint_addsub_pipe_adder #(
    .WIDTH(10), .BLOCK(4), .BLK_PER_STAGE(1)
  ) dut10 (
    .iClk(clk), .iRst(rst), .iValid(n_valid), .oReady(n_rdy_o), .iA(n_a), .iB(n_b),
    .iAddSub(n_addsub), .oValid(n_vld_o), .iReady(n_rdy_in), .oS(n_s_o), .oC(n_c_o)
`ifdef CORDIC_ADDSUB_OVF_EN
    , .oOvf(n_ovf_o)
`endif
  );

  // Reference: 25-bit add or subtract; bit 24 is carry (add) or borrow (subtract).
  function automatic logic [24:0] model(input logic [23:0] x, input logic [23:0] y, input logic m);
    model = m ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op24(input logic [23:0] x, input logic [23:0] y, input logic m,
                      output logic [23:0] s, output logic c, output int lat);
    a = x; b = y; addsub = m; valid = 1'b1;
    tick();
    valid = 1'b0;
    lat = 1;
    while (!vld_o && lat < 12) begin
      tick();
      lat++;
    end
    s = s_o;
    c = c_o;
  endtask

  task automatic op10(input logic [9:0] x, input logic [9:0] y, input logic m,
                      output logic [9:0] s, output logic c, output int lat);
    n_a = x; n_b = y; n_addsub = m; n_valid = 1'b1;
    tick();
    n_valid = 1'b0;
    lat = 1;
    while (!n_vld_o && lat < 12) begin
      tick();
      lat++;
    end
    s = n_s_o;
    c = n_c_o;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; rdy_in = 1'b1; a = '0; b = '0; addsub = 1'b0;
    n_valid = 1'b0; n_rdy_in = 1'b1; n_a = '0; n_b = '0; n_addsub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_total++; if (vld_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", vld_o); else n_pass++;
    n_total++; if (s_o !== 24'h0) $display("FAIL reset_s: got %h want 000000", s_o); else n_pass++;
    n_total++; if (c_o !== 1'b0) $display("FAIL reset_c: got %b want 0", c_o); else n_pass++;
    n_total++; if (rdy_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", rdy_o); else n_pass++;
    n_total++; if (n_vld_o !== 1'b0) $display("FAIL reset_valid10: got %b want 0", n_vld_o); else n_pass++;
  endtask

  task automatic test_single;
    a = 24'h000001; b = 24'h000001; addsub = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    n_total++; if (vld_o !== 1'b0) $display("FAIL single_lat1: got %b want 0", vld_o); else n_pass++;
    tick();
    n_total++; if (vld_o !== 1'b0) $display("FAIL single_lat2: got %b want 0", vld_o); else n_pass++;
    tick();
    n_total++; if (vld_o !== 1'b1) $display("FAIL single_lat3: got %b want 1", vld_o); else n_pass++;
    n_total++; if (s_o !== 24'h000002) $display("FAIL single_s: got %h want 000002", s_o); else n_pass++;
    n_total++; if (c_o !== 1'b0) $display("FAIL single_c: got %b want 0", c_o); else n_pass++;
    tick();
    n_total++; if (vld_o !== 1'b0) $display("FAIL single_once: got %b want 0", vld_o); else n_pass++;
  endtask

  task automatic test_carry;
    logic [23:0] s;
    logic        c;
    int          lat;
    op24(24'hFFFFFF, 24'h000001, 1'b0, s, c, lat);
    n_total++; if (lat !== 3) $display("FAIL carry_lat: got %0d want 3", lat); else n_pass++;
    n_total++; if (s !== 24'h000000) $display("FAIL carry_s: got %h want 000000", s); else n_pass++;
    n_total++; if (c !== 1'b1) $display("FAIL carry_c: got %b want 1", c); else n_pass++;
`ifdef CORDIC_ADDSUB_OVF_EN
    n_total++; if (ovf_o !== 1'b0) $display("FAIL carry_ovf: got %b want 0", ovf_o); else n_pass++;
`endif
    tick();
  endtask

  task automatic test_back_to_back;
    a = 24'h000005; b = 24'h000007; addsub = 1'b1; valid = 1'b1;
    tick();
    a = 24'h000007; b = 24'h000005; addsub = 1'b1;
    tick();
    valid = 1'b0; addsub = 1'b0;
    tick();
    n_total++; if (vld_o !== 1'b1) $display("FAIL b2b_v0: got %b want 1", vld_o); else n_pass++;
    n_total++; if (s_o !== 24'hFFFFFE) $display("FAIL b2b_s0: got %h want fffffe", s_o); else n_pass++;
    n_total++; if (c_o !== 1'b1) $display("FAIL b2b_c0: got %b want 1", c_o); else n_pass++;
    tick();
    n_total++; if (vld_o !== 1'b1) $display("FAIL b2b_v1: got %b want 1", vld_o); else n_pass++;
    n_total++; if (s_o !== 24'h000002) $display("FAIL b2b_s1: got %h want 000002", s_o); else n_pass++;
    n_total++; if (c_o !== 1'b0) $display("FAIL b2b_c1: got %b want 0", c_o); else n_pass++;
    tick();
    n_total++; if (vld_o !== 1'b0) $display("FAIL b2b_end: got %b want 0", vld_o); else n_pass++;
  endtask

  task automatic test_stall;
    logic [23:0] va [8];
    logic [23:0] vb [8];
    logic        vm [8];
    logic [24:0] exp;
    logic [23:0] held_s;
    logic        held_c, acc;
    int          tx, rx, cyc;
    va = '{24'h123456, 24'h800000, 24'hFFFFFF, 24'h000000,
           24'h0ABCDE, 24'h7FFFFF, 24'h00F0F0, 24'h100000};
    vb = '{24'h654321, 24'h000001, 24'hFFFFFF, 24'h000000,
           24'h0ABCDF, 24'h000001, 24'h0F0F0F, 24'h0FFFFF};
    vm = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tx = 0; rx = 0; cyc = 0; held_s = '0; held_c = 1'b0;
    while (rx < 8 && cyc < 60) begin
      rdy_in = !(cyc >= 5 && cyc < 9);
      valid  = (tx < 8);
      if (tx < 8) begin
        a = va[tx]; b = vb[tx]; addsub = vm[tx];
      end
      @(negedge clk);
      if (vld_o && rdy_in) begin
        exp = model(va[rx], vb[rx], vm[rx]);
        n_total++;
        if ({c_o, s_o} !== exp) $display("FAIL stream_beat%0d: got %b_%h want %b_%h",
                                         rx, c_o, s_o, exp[24], exp[23:0]);
        else n_pass++;
        rx++;
      end
      if (!rdy_in) begin
        n_total++;
        if (rdy_o !== 1'b0) $display("FAIL stall_ready: got %b want 0", rdy_o); else n_pass++;
        if (cyc == 5) begin
          held_s = s_o; held_c = c_o;
          n_total++;
          if (vld_o !== 1'b1) $display("FAIL stall_valid: got %b want 1", vld_o); else n_pass++;
        end else begin
          n_total++;
          if ({vld_o, c_o, s_o} !== {1'b1, held_c, held_s})
            $display("FAIL stall_hold: got %b_%b_%h want 1_%b_%h", vld_o, c_o, s_o, held_c, held_s);
          else n_pass++;
        end
      end
      acc = valid && rdy_o;
      tick();
      if (acc) tx++;
      cyc++;
    end
    valid = 1'b0; rdy_in = 1'b1;
    n_total++; if (rx !== 8) $display("FAIL stream_count: got %0d want 8", rx); else n_pass++;
    @(negedge clk);
    n_total++; if (vld_o !== 1'b0) $display("FAIL stream_dup: got %b want 0", vld_o); else n_pass++;
    tick();
  endtask

  task automatic test_reset_inflight;
    logic [23:0] s;
    logic        c;
    int          lat, stale;
    a = 24'h000001; b = 24'h000002; addsub = 1'b0; valid = 1'b1;
    tick();
    a = 24'h000003; b = 24'h000004;
    tick();
    a = 24'h000005; b = 24'h000006;
    tick();
    a = 24'h000007; b = 24'h000008;
    rst = 1'b1;
    tick();
    rst = 1'b0; valid = 1'b0;
    n_total++; if (vld_o !== 1'b0) $display("FAIL rstfl_valid: got %b want 0", vld_o); else n_pass++;
    n_total++; if (s_o !== 24'h0) $display("FAIL rstfl_s: got %h want 000000", s_o); else n_pass++;
    n_total++; if (c_o !== 1'b0) $display("FAIL rstfl_c: got %b want 0", c_o); else n_pass++;
    stale = 0;
    repeat (5) begin
      tick();
      if (vld_o !== 1'b0) stale++;
    end
    n_total++; if (stale !== 0) $display("FAIL rstfl_stale: got %0d want 0", stale); else n_pass++;
    op24(24'h000010, 24'h000020, 1'b0, s, c, lat);
    n_total++; if (lat !== 3) $display("FAIL rstfl_lat: got %0d want 3", lat); else n_pass++;
    n_total++; if ({c, s} !== {1'b0, 24'h000030}) $display("FAIL rstfl_op: got %b_%h want 0_000030", c, s);
    else n_pass++;
    tick();
  endtask

  task automatic test_narrow;
    logic [9:0] s;
    logic       c;
    int         lat;
    op10(10'h3FF, 10'h001, 1'b0, s, c, lat);
    n_total++; if (lat !== 3) $display("FAIL narrow_lat: got %0d want 3", lat); else n_pass++;
    n_total++; if (s !== 10'h000) $display("FAIL narrow_add_s: got %h want 000", s); else n_pass++;
    n_total++; if (c !== 1'b1) $display("FAIL narrow_add_c: got %b want 1", c); else n_pass++;
    tick();
    op10(10'h200, 10'h001, 1'b1, s, c, lat);
    n_total++; if (s !== 10'h1FF) $display("FAIL narrow_sub_s: got %h want 1ff", s); else n_pass++;
    n_total++; if (c !== 1'b0) $display("FAIL narrow_sub_c: got %b want 0", c); else n_pass++;
    tick();
    op10(10'h155, 10'h2AA, 1'b0, s, c, lat);
    n_total++; if ({c, s} !== {1'b0, 10'h3FF}) $display("FAIL narrow_nocarry: got %b_%h want 0_3ff", c, s);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_narrow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cordic_floatingpoint_addsub_pipe_adder.md
Name: cordic_floatingpoint_addsub_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead add/subtract unit for the CORDIC floating-point mantissa datapath. It generalises the fixed 24-bit, 6×4-bit CLA adder to arbitrary width and lookahead-block size, with register cuts between groups of CLA blocks so it closes timing at the CORDIC iteration clock. A valid/ready handshake carries back-pressure so the unit can sit between the alignment shifter and the normaliser.

Parameters:
WIDTH, 24, operand and sum width in bits (≥ 4).
BLOCK, 4, bits per CLA lookahead block; the last block is narrower if WIDTH is not a multiple of BLOCK.
BLK_PER_STAGE, 2, CLA blocks evaluated per pipeline stage. NBLK = ceil(WIDTH/BLOCK). LAT = ceil(NBLK/BLK_PER_STAGE).

Ports:
iClk  input  1  clock; all state updates on its rising edge
iRst  input  1  synchronous reset, active-high
iValid  input  1  operands valid this cycle
oReady  output  1  unit accepts operands this cycle
iA  input  WIDTH  operand A (unsigned magnitude)
iB  input  WIDTH  operand B
iAddSub  input  1  0 = A+B, 1 = A−B
oValid  output  1  result valid
iReady  input  1  downstream accepts result
oS  output  WIDTH  sum/difference, modulo 2^WIDTH
oC  output  1  add: carry-out; subtract: borrow (1 when A<B unsigned)

Behaviour:
- Arithmetic: B' = iB XOR {WIDTH{iAddSub}}; carry-in = iAddSub; S = iA + B' + iAddSub; oC = carry_out(MSB block) XOR iAddSub.
- Stage k (0..LAT−1) computes CLA blocks k·BLK_PER_STAGE .. min(NBLK, (k+1)·BLK_PER_STAGE)−1 using the carry registered by stage k−1. Skew registers delay the unconsumed upper operand bits and the mode bit forward; deskew registers hold the completed lower sum bits until the last stage.
- Latency: exactly LAT cycles from accepted input (iValid && oReady) to oValid, absent stalls. Default: NBLK=6, LAT=3.
- Throughput: one operation per cycle when iReady stays high.
- Handshake: advance = !oValid || iReady; oReady = advance. When advance is high, every stage loads from its predecessor and the per-stage valid bits shift; an input is captured only when iValid && oReady. When advance is low, all pipeline registers and oS/oC/oValid hold unchanged. Bubbles (internal valid=0) are kept in the pipeline and are not compressed.
- oValid, oS and oC are registered and stable while oValid && !iReady.
- Reset: on an iRst-sampled edge, all valid bits clear, oValid=0, oS=0, oC=0, and all data/carry registers clear. oReady=1 from the first cycle after reset. Operations in flight at reset are discarded and produce no output.
- iRst has priority over advance and over simultaneous input acceptance.
- Boundary: full carry propagation (e.g. all-ones + 1) ripples through every stage register and produces the correct result; a narrow final block (WIDTH mod BLOCK ≠ 0) produces its carry from its own top bit.
- Data inputs are don't-care when iValid=0; no X may propagate into oValid.

Optional Feature:
Macro CORDIC_ADDSUB_OVF_EN. When defined, adds output oOvf (1 bit, registered, reset 0, aligned with oValid): two's-complement overflow = carry into MSB XOR carry out of MSB. The MSB carry-in is tracked through the last stage. When undefined, the port, its logic and its registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then iA=0x000001, iB=0x000001, iAddSub=0, single beat, iReady=1 -> oValid rises exactly 3 cycles after acceptance; oS=0x000002, oC=0.
- iA=0xFFFFFF, iB=0x000001, add -> oS=0x000000, oC=1 (carry crosses every stage); with OVF_EN, oOvf=0.
- Subtract 0x000005−0x000007 -> oS=0xFFFFFE, oC=1; subtract 0x000007−0x000005 -> oS=0x000002, oC=0; issue back-to-back and check two consecutive oValid cycles with mode kept aligned per beat.
- Stream 8 random operand pairs with iValid=1; hold iReady=0 for 4 cycles mid-stream -> oReady=0 during the stall, oS/oC/oValid held stable, no beat lost or duplicated, order preserved versus the reference model.
- Assert iRst while 3 operations are in flight -> next cycle oValid=0, oS=0, oC=0; no stale result ever appears; a new operation returns after 3 cycles.
- Rebuild with WIDTH=10, BLOCK=4, BLK_PER_STAGE=1 (NBLK=3, LAT=3): 0x3FF+0x001 -> oS=0x000, oC=1; 0x200−0x001 -> oS=0x1FF, oC=0.
